// File: rtl/palette_access_arbiter.sv
// palette_access_arbiter
//   Time-shares the two 2Kx8 palette RAM halves (upper/lower byte) between
//   the video pixel fetch and 68000 CPU accesses, all in clk_sys.
//   Video fetches always own their slot. CPU writes are posted into a small
//   FIFO and drained in free cycles. CPU reads wait until the FIFO is empty,
//   so a read always sees every earlier write.
//
// Ports
//   clk_sys, nRESET        clock, asynchronous active-low reset
//   PIX_CE, CD, NCBLK      video slot strobe, colour index, composite blank (low)
//   CPU_REQ/WE/A/DIN       CPU request (level, held until CPU_ACK)
//   CPU_DOUT, CPU_ACK      read byte and one-cycle completion pulse
//   RAM_A, RAM_D           palette RAM address / write data (combinational)
//   RAM_WE_HI, RAM_WE_LO   per-half write enables
//   RAM_Q_HI, RAM_Q_LO     per-half read data, one cycle after RAM_A
//   COL, COL_VALID         registered {B,G,R} colour and its update pulse

module palette_access_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 11
) (
    input  logic          clk_sys,
    input  logic          nRESET,
    input  logic          PIX_CE,
    input  logic [9:0]    CD,
    input  logic          NCBLK,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [11:0]   CPU_A,
    input  logic [7:0]    CPU_DIN,
    output logic [7:0]    CPU_DOUT,
    output logic          CPU_ACK,
    output logic [AW-1:0] RAM_A,
    output logic [7:0]    RAM_D,
    output logic          RAM_WE_HI,
    output logic          RAM_WE_LO,
    input  logic [7:0]    RAM_Q_HI,
    input  logic [7:0]    RAM_Q_LO,
    output logic [14:0]   COL,
    output logic          COL_VALID
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PW + 1;

    // Posted write entry: word address, byte select (1 = lower half), data.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          lo;
        logic [7:0]    data;
    } wr_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_ACK,
        RD_WAIT,
        RD_CAP,
        ACK
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Posted-write FIFO
    // ------------------------------------------------------------------
    wr_entry_t        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    wr_entry_t        head;
    wr_entry_t        push_entry;

    // The count register already holds the post-update occupancy of the
    // previous cycle, so full/empty are simple decodes of it.
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = fifo_mem[rd_ptr];

    assign push_entry.addr = AW'(CPU_A[11:1]);
    assign push_entry.lo   = CPU_A[0];
    assign push_entry.data = CPU_DIN;

    // Writes are accepted only from IDLE, which is revisited only after the
    // previous ACK, so a held request cannot be queued twice.
    assign push = (state == IDLE) && CPU_REQ && CPU_WE && !full;

    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slot arbitration: video > FIFO drain > CPU read > idle
    // ------------------------------------------------------------------
    logic video_slot;
    logic rd_issue;

    // A blanked pixel needs no RAM data, so its slot goes to the CPU side.
    assign video_slot = PIX_CE && NCBLK;
    assign pop        = !video_slot && !empty;
    assign rd_issue   = !video_slot && empty && (state == RD_WAIT);

    always_comb begin
        RAM_A     = '0;
        RAM_D     = '0;
        RAM_WE_HI = 1'b0;
        RAM_WE_LO = 1'b0;
        if (video_slot) begin
            RAM_A = AW'({1'b0, CD});
        end else if (pop) begin
            RAM_A     = head.addr;
            RAM_D     = head.data;
            RAM_WE_HI = !head.lo;
            RAM_WE_LO = head.lo;
        end else if (rd_issue) begin
            RAM_A = AW'(CPU_A[11:1]);
        end
    end

    // ------------------------------------------------------------------
    // CPU handshake FSM (registered CPU_ACK / CPU_DOUT)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            CPU_ACK  <= 1'b0;
            CPU_DOUT <= '0;
        end else begin
            CPU_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (CPU_REQ) begin
                        if (CPU_WE) begin
                            // Full FIFO: hold the request in IDLE until a drain frees space.
                            if (push) begin
                                state   <= WR_ACK;
                                CPU_ACK <= 1'b1;
                            end
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                WR_ACK: state <= IDLE;
                RD_WAIT: begin
                    if (rd_issue)
                        state <= RD_CAP;
                end
                RD_CAP: begin
                    // RAM data for the address issued last cycle is on RAM_Q now.
                    CPU_DOUT <= CPU_A[0] ? RAM_Q_LO : RAM_Q_HI;
                    CPU_ACK  <= 1'b1;
                    state    <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Video pipeline: slot at t, RAM data during t+1, COL valid in t+2
    // ------------------------------------------------------------------
    logic [1:0] vld_pipe;
    logic       blank_q;
    logic       unused_q_hi7;

    // Bit 7 of the upper half is not part of the 15-bit colour.
    assign unused_q_hi7 = RAM_Q_HI[7];
    assign COL_VALID    = vld_pipe[1];

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            vld_pipe <= '0;
            blank_q  <= 1'b0;
            COL      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], PIX_CE};
            blank_q  <= !NCBLK;
            if (vld_pipe[0])
                COL <= blank_q ? 15'd0 : {RAM_Q_HI[6:0], RAM_Q_LO};
        end
    end

endmodule

// File: tb/tb_palette_access_arbiter.sv
// Directed bench for palette_access_arbiter: inputs driven on the falling
// edge, outputs sampled 1 ns later; a behavioural 2x2Kx8 RAM with one-cycle
// read latency sits on the RAM port and a monitor logs every RAM write.

module tb_palette_access_arbiter;

    logic        clk_sys = 1'b0;
    logic        nRESET  = 1'b0;
    logic        PIX_CE;
    logic [9:0]  CD;
    logic        NCBLK;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [11:0] CPU_A;
    logic [7:0]  CPU_DIN;
    logic [7:0]  CPU_DOUT;
    logic        CPU_ACK;
    logic [10:0] RAM_A;
    logic [7:0]  RAM_D;
    logic        RAM_WE_HI;
    logic        RAM_WE_LO;
    logic [7:0]  RAM_Q_HI;
    logic [7:0]  RAM_Q_LO;
    logic [14:0] COL;
    logic        COL_VALID;

    palette_access_arbiter #(.FIFO_DEPTH(4), .AW(11)) dut (
        .clk_sys   (clk_sys),
        .nRESET    (nRESET),
        .PIX_CE    (PIX_CE),
        .CD        (CD),
        .NCBLK     (NCBLK),
        .CPU_REQ   (CPU_REQ),
        .CPU_WE    (CPU_WE),
        .CPU_A     (CPU_A),
        .CPU_DIN   (CPU_DIN),
        .CPU_DOUT  (CPU_DOUT),
        .CPU_ACK   (CPU_ACK),
        .RAM_A     (RAM_A),
        .RAM_D     (RAM_D),
        .RAM_WE_HI (RAM_WE_HI),
        .RAM_WE_LO (RAM_WE_LO),
        .RAM_Q_HI  (RAM_Q_HI),
        .RAM_Q_LO  (RAM_Q_LO),
        .COL       (COL),
        .COL_VALID (COL_VALID)
    );

    always #5 clk_sys = ~clk_sys;

    // Palette RAM model
    logic [7:0] mem_hi [2048];
    logic [7:0] mem_lo [2048];

    always @(posedge clk_sys) begin
        if (RAM_WE_HI) mem_hi[RAM_A] <= RAM_D;
        if (RAM_WE_LO) mem_lo[RAM_A] <= RAM_D;
        RAM_Q_HI <= mem_hi[RAM_A];
        RAM_Q_LO <= mem_lo[RAM_A];
    end

    // Write log {addr, we_hi, we_lo, data} and ACK counter
    logic [20:0] wr_log [$];
    int          ack_cnt = 0;

    always @(negedge clk_sys) begin
        #2;
        if (nRESET && (RAM_WE_HI || RAM_WE_LO))
            wr_log.push_back({RAM_A, RAM_WE_HI, RAM_WE_LO, RAM_D});
        if (CPU_ACK)
            ack_cnt++;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] exp_wr(input logic [11:0] a, input logic [7:0] d);
        return {a[11:1], ~a[0], a[0], d};
    endfunction

    task automatic cpu_write(input logic [11:0] a, input logic [7:0] d, input int budget,
                             output bit acked);
        acked = 1'b0;
        for (int i = 0; i < budget && !acked; i++) begin
            @(negedge clk_sys);
            CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_A = a; CPU_DIN = d;
            #1;
            if (CPU_ACK) acked = 1'b1;
        end
    endtask

    task automatic cpu_read(input logic [11:0] a, input int budget,
                            output bit acked, output logic [7:0] data);
        acked = 1'b0;
        data  = '0;
        for (int i = 0; i < budget && !acked; i++) begin
            @(negedge clk_sys);
            CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_A = a; CPU_DIN = '0;
            #1;
            if (CPU_ACK) begin
                acked = 1'b1;
                data  = CPU_DOUT;
            end
        end
    endtask

    logic [11:0] bp_a [5];
    logic [7:0]  bp_d [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit         ok;
        logic [7:0] rd;
        int         lb;
        int         ab;

        PIX_CE = 0; CD = '0; NCBLK = 1; CPU_REQ = 0; CPU_WE = 0; CPU_A = '0; CPU_DIN = '0;
        for (int i = 0; i < 2048; i++) begin
            mem_hi[i] <= 8'h00;
            mem_lo[i] <= 8'h00;
        end
        mem_hi[11'h155] <= 8'h7C;
        mem_lo[11'h155] <= 8'h1F;
        bp_a = '{12'h100, 12'h103, 12'h104, 12'h107, 12'h108};
        bp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Reset state
        repeat (3) @(negedge clk_sys);
        #1;
        chk("rst_ack", 32'(CPU_ACK), 0);
        chk("rst_dout", 32'(CPU_DOUT), 0);
        chk("rst_col", 32'(COL), 0);
        chk("rst_col_valid", 32'(COL_VALID), 0);
        chk("rst_we", 32'({RAM_WE_HI, RAM_WE_LO}), 0);
        @(negedge clk_sys);
        nRESET = 1'b1;

        // Idle video fetch every 8 cycles
        for (int f = 0; f < 3; f++) begin
            @(negedge clk_sys); PIX_CE = 1; CD = 10'h155; #1;
            chk("idle_ram_a", 32'(RAM_A), 'h155);
            chk("idle_no_we", 32'({RAM_WE_HI, RAM_WE_LO}), 0);
            @(negedge clk_sys); PIX_CE = 0; #1;
            chk("idle_cv_early", 32'(COL_VALID), 0);
            @(negedge clk_sys); #1;
            chk("idle_col_valid", 32'(COL_VALID), 1);
            chk("idle_col", 32'(COL), 'h7C1F);
            repeat (5) @(negedge clk_sys);
        end

        // Write in the same cycle as a video slot
        @(negedge clk_sys);
        PIX_CE = 1; CD = 10'h155; CPU_REQ = 1; CPU_WE = 1; CPU_A = 12'h2AB; CPU_DIN = 8'h00;
        #1;
        chk("wdv_video_a", 32'(RAM_A), 'h155);
        chk("wdv_video_no_we", 32'({RAM_WE_HI, RAM_WE_LO}), 0);
        chk("wdv_no_ack_yet", 32'(CPU_ACK), 0);
        @(negedge clk_sys); PIX_CE = 0; #1;
        chk("wdv_we_lo", 32'({RAM_WE_HI, RAM_WE_LO}), 'b01);
        chk("wdv_drain_a", 32'(RAM_A), 'h155);
        chk("wdv_drain_d", 32'(RAM_D), 'h00);
        chk("wdv_ack", 32'(CPU_ACK), 1);
        @(negedge clk_sys); CPU_REQ = 0; #1;
        chk("wdv_ack_once", 32'(CPU_ACK), 0);
        chk("wdv_col_old", 32'(COL), 'h7C1F);
        repeat (4) @(negedge clk_sys);
        @(negedge clk_sys); PIX_CE = 1; CD = 10'h155;
        @(negedge clk_sys); PIX_CE = 0;
        @(negedge clk_sys); #1;
        chk("wdv_col_valid", 32'(COL_VALID), 1);
        chk("wdv_col_new", 32'(COL), 'h7C00);

        // Backpressure: video owns every slot, FIFO fills at 4
        @(negedge clk_sys); PIX_CE = 1; NCBLK = 1; CD = '0;
        lb = wr_log.size();
        for (int i = 0; i < 4; i++) begin
            cpu_write(bp_a[i], bp_d[i], 4, ok);
            chk("bp_ack", 32'(ok), 1);
        end
        cpu_write(bp_a[4], bp_d[4], 8, ok);
        chk("bp_5th_held", 32'(ok), 0);
        chk("bp_no_drain", wr_log.size() - lb, 0);
        @(negedge clk_sys); PIX_CE = 0;
        cpu_write(bp_a[4], bp_d[4], 8, ok);
        chk("bp_5th_ack", 32'(ok), 1);
        @(negedge clk_sys); CPU_REQ = 0;
        repeat (6) @(negedge clk_sys);
        chk("bp_drain_cnt", wr_log.size() - lb, 5);
        for (int i = 0; i < 5; i++) begin
            if (lb + i < wr_log.size())
                chk("bp_order", 32'(wr_log[lb + i]), 32'(exp_wr(bp_a[i], bp_d[i])));
            else
                chk("bp_order_missing", wr_log.size() - lb, i + 1);
        end

        // Read after queued writes (last write to 0x010 upper wins)
        @(negedge clk_sys); PIX_CE = 1; CD = '0;
        lb = wr_log.size();
        cpu_write(12'h020, 8'h99, 4, ok); chk("raw_w1_ack", 32'(ok), 1);
        cpu_write(12'h031, 8'hB2, 4, ok); chk("raw_w2_ack", 32'(ok), 1);
        cpu_write(12'h020, 8'h5A, 4, ok); chk("raw_w3_ack", 32'(ok), 1);
        chk("raw_queued", wr_log.size() - lb, 0);
        @(negedge clk_sys); PIX_CE = 0; CPU_REQ = 0;
        cpu_read(12'h020, 12, ok, rd);
        chk("raw_rd_ack", 32'(ok), 1);
        chk("raw_dout", 32'(rd), 'h5A);
        chk("raw_drains_before_ack", wr_log.size() - lb, 3);
        @(negedge clk_sys); CPU_REQ = 0;
        repeat (2) @(negedge clk_sys);

        // Blank releases the video slot to a pending write
        @(negedge clk_sys); PIX_CE = 1; NCBLK = 1; CD = 10'h155;
        cpu_write(12'h0A1, 8'h77, 4, ok);
        chk("blk_w_ack", 32'(ok), 1);
        @(negedge clk_sys); CPU_REQ = 0; NCBLK = 0; #1;
        chk("blk_we", 32'({RAM_WE_HI, RAM_WE_LO}), 'b01);
        chk("blk_a", 32'(RAM_A), 'h050);
        chk("blk_d", 32'(RAM_D), 'h77);
        @(negedge clk_sys); PIX_CE = 0; NCBLK = 1; #1;
        chk("blk_prev_col", 32'(COL), 'h7C00);
        @(negedge clk_sys); #1;
        chk("blk_col_valid", 32'(COL_VALID), 1);
        chk("blk_col_zero", 32'(COL), 0);
        @(negedge clk_sys); #1;
        chk("blk_cv_end", 32'(COL_VALID), 0);

        // Reset while a read waits behind 2 queued writes
        @(negedge clk_sys); PIX_CE = 1; NCBLK = 1; CD = '0;
        lb = wr_log.size();
        cpu_write(12'h200, 8'hC1, 4, ok); chk("rr_w1_ack", 32'(ok), 1);
        cpu_write(12'h203, 8'hC2, 4, ok); chk("rr_w2_ack", 32'(ok), 1);
        @(negedge clk_sys); CPU_REQ = 1; CPU_WE = 0; CPU_A = 12'h200;
        repeat (2) @(negedge clk_sys);
        #1;
        chk("rr_wait_no_ack", 32'(CPU_ACK), 0);
        ab = ack_cnt;
        nRESET = 1'b0;
        @(negedge clk_sys); CPU_REQ = 0; PIX_CE = 0; #1;
        chk("rr_dout_cleared", 32'(CPU_DOUT), 0);
        chk("rr_we_in_reset", 32'({RAM_WE_HI, RAM_WE_LO}), 0);
        @(negedge clk_sys); nRESET = 1'b1;
        repeat (6) @(negedge clk_sys);
        #1;
        chk("rr_no_drain", wr_log.size() - lb, 0);
        chk("rr_no_ack", ack_cnt - ab, 0);
        cpu_write(12'h301, 8'h3C, 4, ok);
        chk("rr_next_ack", 32'(ok), 1);
        @(negedge clk_sys); CPU_REQ = 0;
        repeat (2) @(negedge clk_sys);
        chk("rr_next_drain", wr_log.size() - lb, 1);
        if (wr_log.size() > lb)
            chk("rr_next_entry", 32'(wr_log[lb]), 32'(exp_wr(12'h301, 8'h3C)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
